mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage load/store unit in front of a word-wide, word-write-
//             only data memory. Handles byte/halfword/word loads with sign or
//             zero extension, word stores in one cycle, and sub-word stores
//             as a two-cycle read-modify-write. Misaligned or illegal-size
//             requests raise a one-cycle fault pulse and touch no memory.
//  Ports    :
//    clk, rst_n                 clock, asynchronous active-low reset
//    req_valid/we/size/unsigned request qualifiers from the pipeline
//    req_addr, req_wdata        byte address and right-justified store data
//    stall                      hold the MEM stage (sub-word store accept)
//    ld_valid, ld_data          registered load result, one-cycle pulse
//    misaligned                 registered fault pulse
//    mem_A, mem_WE, mem_WD      data memory address / write enable / data
//    mem_RD                     combinational read word at mem_A[31:2]
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misaligned,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] addr_q, addr_d;

    logic        w_accept;
    logic        w_fault;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_ld_ext;
    logic [31:0] w_merged;

    // rst_n gates acceptance so no combinational write can leak out while
    // the block is held in reset.
    assign w_accept = rst_n && (state_q == IDLE) && req_valid;

    assign w_fault = (req_size == 2'b11)
                  || ((req_size == c_SIZE_HALF) && req_addr[0])
                  || ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00));

    // Lane selection of the read word (little-endian, lane n = bits 8n+7:8n)
    always_comb begin
        w_rd_byte = mem_RD[7:0];
        case (req_addr[1:0])
            2'd0:    w_rd_byte = mem_RD[7:0];
            2'd1:    w_rd_byte = mem_RD[15:8];
            2'd2:    w_rd_byte = mem_RD[23:16];
            default: w_rd_byte = mem_RD[31:24];
        endcase
    end

    assign w_rd_half = req_addr[1] ? mem_RD[31:16] : mem_RD[15:0];

    always_comb begin
        w_ld_ext = mem_RD;
        case (req_size)
            c_SIZE_BYTE: w_ld_ext = {{24{~req_unsigned & w_rd_byte[7]}}, w_rd_byte};
            c_SIZE_HALF: w_ld_ext = {{16{~req_unsigned & w_rd_half[15]}}, w_rd_half};
            default:     w_ld_ext = mem_RD;
        endcase
    end

    // Merge store data into the addressed lane(s); untouched lanes keep mem_RD
    always_comb begin
        w_merged = mem_RD;
        if (req_size == c_SIZE_HALF) begin
            if (req_addr[1]) w_merged[31:16] = req_wdata[15:0];
            else             w_merged[15:0]  = req_wdata[15:0];
        end else begin
            case (req_addr[1:0])
                2'd0:    w_merged[7:0]   = req_wdata[7:0];
                2'd1:    w_merged[15:8]  = req_wdata[7:0];
                2'd2:    w_merged[23:16] = req_wdata[7:0];
                default: w_merged[31:24] = req_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_valid_d   = 1'b0;
        ld_data_d    = ld_data_q;
        misaligned_d = 1'b0;
        merged_d     = merged_q;
        addr_d       = addr_q;
        mem_A        = req_addr;
        mem_WE       = 1'b0;
        mem_WD       = 32'd0;
        stall        = 1'b0;

        if (state_q == RMW_WR) begin
            // Second half of a sub-word store; the held request is ignored
            mem_A   = addr_q;
            mem_WE  = 1'b1;
            mem_WD  = merged_q;
            state_d = IDLE;
        end else if (w_accept) begin
            if (w_fault) begin
                misaligned_d = 1'b1;
            end else if (!req_we) begin
                ld_valid_d = 1'b1;
                ld_data_d  = w_ld_ext;
            end else if (req_size == c_SIZE_WORD) begin
                mem_WE = 1'b1;
                mem_WD = req_wdata;
            end else begin
                stall    = 1'b1;
                merged_d = w_merged;
                addr_d   = {req_addr[31:2], 2'b00};
                state_d  = RMW_WR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ld_valid_q   <= 1'b0;
            ld_data_q    <= 32'd0;
            misaligned_q <= 1'b0;
            merged_q     <= 32'd0;
            addr_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            ld_valid_q   <= ld_valid_d;
            ld_data_q    <= ld_data_d;
            misaligned_q <= misaligned_d;
            merged_q     <= merged_d;
            addr_q       <= addr_d;
        end
    end

    assign ld_valid   = ld_valid_q;
    assign ld_data    = ld_data_q;
    assign misaligned = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit: directed vector table,
//             reset-during-RMW sequence, and randomized requests checked
//             against an arithmetic reference model of memory contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misaligned;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .misaligned   (misaligned),
        .mem_A        (mem_A),
        .mem_WE       (mem_WE),
        .mem_WD       (mem_WD),
        .mem_RD       (mem_RD)
    );

    // Data memory driven by the DUT (16 words)
    logic [31:0] mem [16];
    assign mem_RD = mem[mem_A[5:2]];
    always @(posedge clk) if (mem_WE) mem[mem_A[5:2]] <= mem_WD;

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] last_ld;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_ld;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_mem();
        int diff = -1;
        total++;
        for (int k = 0; k < 16; k++) if (mem[k] !== ref_mem[k] && diff < 0) diff = k;
        if (diff >= 0) begin
            bad++;
            $display("FAIL mem_contents: word %0d got %h want %h", diff, mem[diff], ref_mem[diff]);
        end
    endtask

    function automatic bit is_fault(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [31:0] a);
        logic [31:0] w = ref_mem[a[5:2]];
        logic [31:0] v = w >> (8 * (a % 4));
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w = ref_mem[a[5:2]];
        logic [31:0] sh = 8 * (a % 4);
        logic [31:0] mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit          f;
        bit          sub;
        bit          wst;
        logic [31:0] exp_ld;
        logic [31:0] new_word;
        exp_ld   = 32'd0;
        new_word = 32'd0;
        @(negedge clk);
        compare_mem();
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        f   = is_fault(size, addr);
        sub = we && !f && size != 2'd2;
        wst = we && !f && size == 2'd2;
        if (!we && !f) exp_ld = model_load(size, uns, addr);
        if (we && !f)  new_word = model_store(size, addr, wdata);
        #1;
        check("acc_mem_A", mem_A, addr);
        check("acc_stall", 32'(stall), 32'(sub));
        check("acc_mem_WE", 32'(mem_WE), 32'(wst));
        check("acc_mem_WD", mem_WD, wst ? wdata : 32'd0);
        @(posedge clk); #1;
        check("misaligned", 32'(misaligned), 32'(f));
        check("ld_valid", 32'(ld_valid), 32'(!we && !f));
        if (!we && !f) last_ld = exp_ld;
        check("ld_data", ld_data, last_ld);
        if (we && !f) ref_mem[addr[5:2]] = new_word;
        if (sub) begin
            check("rmw_mem_WE", 32'(mem_WE), 32'd1);
            check("rmw_mem_WD", mem_WD, new_word);
            check("rmw_mem_A", {mem_A[31:2], 2'b00}, {addr[31:2], 2'b00});
            check("rmw_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            // held request must not have been re-accepted during RMW_WR
            check("rmw_no_reaccept", 32'(mem_WE), 32'd0);
            check("rmw_no_pulse", 32'(ld_valid | misaligned), 32'd0);
        end
    endtask

    task automatic do_idle();
        @(negedge clk);
        compare_mem();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        #1;
        check("idle_mem_A", mem_A, req_addr);
        check("idle_mem_WE", 32'(mem_WE), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("idle_pulses", 32'(ld_valid | misaligned), 32'd0);
        check("idle_ld_hold", ld_data, last_ld);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            mem[k] = 32'd0;
            ref_mem[k] = 32'd0;
        end
        mem[0] = 32'h0000_0028; ref_mem[0] = 32'h0000_0028;
        mem[1] = 32'h1234_5678; ref_mem[1] = 32'h1234_5678;
        last_ld = 32'd0;

        //           we    size   uns   addr    wdata          exp_ld         exp_word
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,         32'h0000_0028, 32'h0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h2, 32'h0000_00FF, 32'h0,         32'h00FF_0028};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h2, 32'h0,         32'hFFFF_FFFF, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h2, 32'h0,         32'h0000_00FF, 32'h0};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h4, 32'h0000_8001, 32'h0,         32'h1234_8001};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h4, 32'h0,         32'hFFFF_8001, 32'h0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h6, 32'hCAFE_F00D, 32'h0,         32'h1234_8001};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF, 32'h0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0,         32'hDEAD_BEEF, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h3, 32'h0,         32'hDEAD_BEEF, 32'h0};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'hA, 32'h1234_ABCD, 32'h0,         32'hABCD_BEEF};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 32'hB, 32'h0,         32'h0000_00AB, 32'h0};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 32'h2, 32'h0,         32'h0000_00FF, 32'h0};

        // Reset with a word store presented: nothing may leak out
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ld_valid", 32'(ld_valid), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_WE", 32'(mem_WE), 32'd0);
        check("rst_mem_WD", mem_WD, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;

        // Directed table; first entry is accepted on the first edge after reset
        for (int i = 0; i < 14; i++) begin
            logic [31:0] a;
            a = vecs[i].addr;
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, a, vecs[i].wdata);
            if (!vecs[i].we) check("vec_ld_data", ld_data, vecs[i].exp_ld);
            else             check("vec_mem_word", mem[a[5:2]], vecs[i].exp_word);
        end

        // Reset asserted while the RMW write is pending
        @(negedge clk);
        compare_mem();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000_00AB;
        #1;
        check("rrmw_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("rrmw_pending_WE", 32'(mem_WE), 32'd1);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rrmw_mem_WE", 32'(mem_WE), 32'd0);
        check("rrmw_mem_WD", mem_WD, 32'd0);
        check("rrmw_stall0", 32'(stall), 32'd0);
        check("rrmw_ld_data", ld_data, 32'd0);
        check("rrmw_pulses", 32'(ld_valid | misaligned), 32'd0);
        @(posedge clk); #1;
        check("rrmw_word_unchanged", mem[4], 32'd0);
        rst_n = 1'b1;
        last_ld = 32'd0;
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                do_idle();
            end else begin
                do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                       32'($urandom_range(0, 63)), $urandom);
            end
        end
        do_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
